// File: rtl/core_pkg.sv
// core_pkg: shared types and default widths for the RISC-V pipeline stages.
//   alu_op_t     - 3-bit ALU operation encoding
//   fwd_sel_t    - 2-bit operand forwarding select (11 behaves like FWD_REG)
//   result_src_t - 2-bit writeback source select
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REGW_DEF = 5;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

endpackage

// File: rtl/ie_im_stage_alu.sv
// alu: purely combinational integer ALU for the execute stage.
//   src_a, src_b : operands
//   alu_op       : operation (alu_op_t)
//   alu_result   : result, add/sub wrap modulo 2^W
//   zero         : alu_result == 0
module alu
  import core_pkg::*;
#(
  parameter int W = XLEN_DEF
) (
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  alu_op_t      alu_op,
  output logic [W-1:0] alu_result,
  output logic         zero
);

  logic slt_bit;

  assign slt_bit = ($signed(src_a) < $signed(src_b));

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_SUB: alu_result = src_a - src_b;
      ALU_AND: alu_result = src_a & src_b;
      ALU_OR:  alu_result = src_a | src_b;
      ALU_XOR: alu_result = src_a ^ src_b;
      ALU_SLT: alu_result = {{(W-1){1'b0}}, slt_bit};
      // Only the low five bits of src_b give the shift amount.
      ALU_SLL: alu_result = src_a << src_b[4:0];
      ALU_SRL: alu_result = src_a >> src_b[4:0];
      default: alu_result = src_a + src_b;
    endcase
  end

  assign zero = (alu_result == '0);

endmodule

// File: rtl/ie_im_stage.sv
// ie_im_stage: execute stage plus EX/MEM pipeline register.
//   Inputs : E-stage control/data bundle, ResultW for forwarding,
//            ForwardAE/ForwardBE selects, StallM/FlushM from the hazard unit.
//   Outputs: PCSrcE/PCTargetE (combinational redirect) and the registered
//            M-stage bundle (RegWriteM .. PCPlus4M).
//   Reset  : 'reset' is asynchronous and active-low; it clears only the
//            M-stage register.
module ie_im_stage
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int REGW = REGW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            RegWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            BranchE,
  input  logic [2:0]      ALUControlE,
  input  logic            ALUSrcE,
  input  logic [XLEN-1:0] RD1E,
  input  logic [XLEN-1:0] RD2E,
  input  logic [XLEN-1:0] PCE,
  input  logic [REGW-1:0] RdE,
  input  logic [XLEN-1:0] ImmExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [XLEN-1:0] ResultW,
  input  logic [1:0]      ForwardAE,
  input  logic [1:0]      ForwardBE,
  input  logic            StallM,
  input  logic            FlushM,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE,
  output logic            RegWriteM,
  output logic [1:0]      ResultSrcM,
  output logic            MemWriteM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [REGW-1:0] RdM,
  output logic [XLEN-1:0] PCPlus4M
);

  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] write_data_e;
  logic [XLEN-1:0] src_b;
  logic [XLEN-1:0] alu_result_e;
  logic            zero_e;

  // Forward select 10 reads this block's own ALUResultM, so while the
  // M register is stalled the forwarded value stays the held result.
  always_comb begin
    src_a = RD1E;
    case (fwd_sel_t'(ForwardAE))
      FWD_W:   src_a = ResultW;
      FWD_M:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
  end

  always_comb begin
    write_data_e = RD2E;
    case (fwd_sel_t'(ForwardBE))
      FWD_W:   write_data_e = ResultW;
      FWD_M:   write_data_e = ALUResultM;
      default: write_data_e = RD2E;
    endcase
  end

  assign src_b = ALUSrcE ? ImmExtE : write_data_e;

  alu #(.W(XLEN)) u_alu (
    .src_a      (src_a),
    .src_b      (src_b),
    .alu_op     (alu_op_t'(ALUControlE)),
    .alu_result (alu_result_e),
    .zero       (zero_e)
  );

  // Redirect is resolved in the same cycle; squashing is left to the
  // hazard unit upstream.
  assign PCTargetE = PCE + ImmExtE;
  assign PCSrcE    = JumpE | (BranchE & zero_e);

  // Flush wins over stall so a bubble can be inserted into a held slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
      PCPlus4M   <= '0;
    end else if (FlushM) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= 2'b00;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
      PCPlus4M   <= '0;
    end else if (!StallM) begin
      RegWriteM  <= RegWriteE;
      ResultSrcM <= ResultSrcE;
      MemWriteM  <= MemWriteE;
      ALUResultM <= alu_result_e;
      WriteDataM <= write_data_e;
      RdM        <= RdE;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_ie_im_stage.sv
module tb_ie_im_stage;

  localparam int BW = 1 + 2 + 1 + 32 + 32 + 5 + 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, StallM, FlushM;
  logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E, ResultW;
  logic [4:0]  RdE;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;

  int n_cmp = 0;
  int n_fail = 0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] last_exp;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rd1, rd2, imm, resw;
    logic        alusrc;
    logic [1:0]  fa, fb;
    logic [31:0] exp_alu, exp_wd;
  } vec_t;

  vec_t vecs[15];

  ie_im_stage dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE),
    .JumpE(JumpE), .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .RdE(RdE), .ImmExtE(ImmExtE),
    .PCPlus4E(PCPlus4E), .ResultW(ResultW), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallM(StallM), .FlushM(FlushM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
    .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .RdM(RdM), .PCPlus4M(PCPlus4M)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  function automatic vec_t mk(input logic [2:0] op, input logic [31:0] rd1, rd2, imm, resw,
                              input logic alusrc, input logic [1:0] fa, fb,
                              input logic [31:0] exp_alu, exp_wd);
    vec_t v;
    v.op = op; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.resw = resw;
    v.alusrc = alusrc; v.fa = fa; v.fb = fb; v.exp_alu = exp_alu; v.exp_wd = exp_wd;
    return v;
  endfunction

  function automatic logic [BW-1:0] m_actual();
    return {RegWriteM, ResultSrcM, MemWriteM, ALUResultM, WriteDataM, RdM, PCPlus4M};
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    RegWriteE = 0; ResultSrcE = 0; MemWriteE = 0; JumpE = 0; BranchE = 0;
    ALUControlE = 0; ALUSrcE = 0; RD1E = 0; RD2E = 0; PCE = 0; RdE = 0;
    ImmExtE = 0; PCPlus4E = 0; ResultW = 0; ForwardAE = 0; ForwardBE = 0;
    StallM = 0; FlushM = 0;
  endtask

  task automatic drive_random_ctrl();
    RegWriteE  = 1'($urandom_range(0, 1));
    ResultSrcE = 2'($urandom_range(0, 3));
    MemWriteE  = 1'($urandom_range(0, 1));
    RdE        = 5'($urandom_range(0, 31));
    PCPlus4E   = $urandom;
  endtask

  // Advance one clock and settle just past the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Push the expected M bundle for the currently driven E bundle, clock it
  // in, then pop and compare.
  task automatic capture(input string name, input logic [31:0] exp_alu, input logic [31:0] exp_wd);
    logic [BW-1:0] e;
    exp_q.push_back({RegWriteE, ResultSrcE, MemWriteE, exp_alu, exp_wd, RdE, PCPlus4E});
    step();
    if (exp_q.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = exp_q.pop_front();
      last_exp = e;
      check(name, m_actual(), e);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = mk(3'b000, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 2'b00, 2'b00, 32'h0, 32'h1);
    vecs[1]  = mk(3'b001, 32'h10, 32'h20, 0, 0, 0, 2'b00, 2'b00, 32'hFFFFFFF0, 32'h20);
    vecs[2]  = mk(3'b010, 32'hF0F0F0F0, 32'h0FF00FF0, 0, 0, 0, 2'b00, 2'b00, 32'h00F000F0, 32'h0FF00FF0);
    vecs[3]  = mk(3'b011, 32'hF0000000, 32'h0000000F, 0, 0, 0, 2'b00, 2'b00, 32'hF000000F, 32'h0000000F);
    vecs[4]  = mk(3'b100, 32'hFFFF0000, 32'h0F0F0F0F, 0, 0, 0, 2'b00, 2'b00, 32'hF0F00F0F, 32'h0F0F0F0F);
    vecs[5]  = mk(3'b101, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 2'b00, 2'b00, 32'h1, 32'h1);
    vecs[6]  = mk(3'b101, 32'h1, 32'hFFFFFFFF, 0, 0, 0, 2'b00, 2'b00, 32'h0, 32'hFFFFFFFF);
    vecs[7]  = mk(3'b111, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 2'b00, 2'b00, 32'h7FFFFFFF, 32'h1);
    vecs[8]  = mk(3'b110, 32'hFFFFFFFF, 32'h21, 0, 0, 0, 2'b00, 2'b00, 32'hFFFFFFFE, 32'h21);
    vecs[9]  = mk(3'b000, 32'h100, 32'hDEAD, 32'h20, 0, 1, 2'b00, 2'b00, 32'h120, 32'hDEAD);
    vecs[10] = mk(3'b000, 32'h1, 32'h2, 0, 32'h55, 0, 2'b01, 2'b00, 32'h57, 32'h2);
    vecs[11] = mk(3'b000, 32'h3, 32'h4, 0, 32'h99, 0, 2'b11, 2'b11, 32'h7, 32'h4);
    vecs[12] = mk(3'b011, 32'h100, 32'h7, 0, 32'h0F, 0, 2'b00, 2'b01, 32'h10F, 32'h0F);
    vecs[13] = mk(3'b111, 32'h80000000, 32'd31, 0, 0, 0, 2'b00, 2'b00, 32'h1, 32'd31);
    vecs[14] = mk(3'b001, 32'h0, 32'h1, 0, 0, 0, 2'b00, 2'b00, 32'hFFFFFFFF, 32'h1);

    // Reset held with random inputs.
    reset = 1'b0;
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      drive_random_ctrl();
      RD1E = $urandom; RD2E = $urandom; ALUControlE = 3'($urandom_range(0, 7));
      step();
      check("reset_hold", m_actual(), '0);
    end

    // Release between edges; first posedge after release captures.
    reset = 1'b1;
    drive_idle();
    drive_random_ctrl();
    RegWriteE = 1'b1;
    RD1E = 32'h1234_0000; RD2E = 32'h0000_5678;
    capture("reset_release", 32'h1234_5678, 32'h0000_5678);

    // Table-driven ALU / mux sweep.
    for (int i = 0; i < 15; i++) begin
      drive_idle();
      drive_random_ctrl();
      ALUControlE = vecs[i].op; RD1E = vecs[i].rd1; RD2E = vecs[i].rd2;
      ImmExtE = vecs[i].imm; ResultW = vecs[i].resw; ALUSrcE = vecs[i].alusrc;
      ForwardAE = vecs[i].fa; ForwardBE = vecs[i].fb;
      capture($sformatf("vec%0d", i), vecs[i].exp_alu, vecs[i].exp_wd);
    end

    // Forwarding from M (own register) and W.
    drive_idle(); drive_random_ctrl();
    RD1E = 32'h10;
    capture("fwd_setup", 32'h10, 32'h0);
    drive_idle(); drive_random_ctrl();
    ResultW = 32'h20; ForwardAE = 2'b10; ForwardBE = 2'b01;
    capture("fwd_m_w", 32'h30, 32'h20);

    // Stall: M held, forward-10 keeps seeing the held 0x30 (sub -> zero).
    for (int i = 0; i < 3; i++) begin
      drive_idle(); drive_random_ctrl();
      RD1E = $urandom; RD2E = $urandom;
      StallM = 1'b1; ForwardAE = 2'b10; ALUSrcE = 1'b1; ImmExtE = 32'h30;
      ALUControlE = 3'b001; BranchE = 1'b1; PCE = 32'h400;
      #1;
      check("stall_fwd_m_pcsrc", BW'(PCSrcE), BW'(1'b1));
      step();
      check("stall_hold", m_actual(), last_exp);
    end

    // Flush wins over stall.
    drive_idle(); drive_random_ctrl();
    RD1E = $urandom;
    StallM = 1'b1; FlushM = 1'b1;
    step();
    check("flush_over_stall", m_actual(), '0);

    // Branch taken / not taken, same-cycle redirect.
    drive_idle(); drive_random_ctrl();
    BranchE = 1'b1; RD1E = 32'd5; RD2E = 32'd5; ALUControlE = 3'b001;
    PCE = 32'h100; ImmExtE = 32'hFFFFFFF0;
    #1;
    check("beq_taken_pcsrc", BW'(PCSrcE), BW'(1'b1));
    check("beq_target", BW'(PCTargetE), BW'(32'hF0));
    RD2E = 32'd6;
    #1;
    check("beq_not_taken_pcsrc", BW'(PCSrcE), BW'(1'b0));
    capture("beq_capture", 32'hFFFFFFFF, 32'd6);

    // Asynchronous reset pulse between edges.
    drive_idle(); drive_random_ctrl();
    RD1E = 32'hCAFE;
    capture("pre_async", 32'hCAFE, 32'h0);
    #1 reset = 1'b0;
    #1;
    check("async_reset", m_actual(), '0);
    reset = 1'b1;

    // Jump.
    drive_idle(); drive_random_ctrl();
    JumpE = 1'b1; PCE = 32'h200; ImmExtE = 32'h8; PCPlus4E = 32'h204; ResultSrcE = 2'b10;
    #1;
    check("jal_pcsrc", BW'(PCSrcE), BW'(1'b1));
    check("jal_target", BW'(PCTargetE), BW'(32'h208));
    capture("jal_capture", 32'h0, 32'h0);
    check("jal_pcplus4m", BW'(PCPlus4M), BW'(32'h204));
    check("jal_resultsrcm", BW'(ResultSrcM), BW'(2'b10));

    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
